// File: rtl/ram_based_cam_if.sv
// Bus bundle for the RAM-based ternary CAM: the write channel
// (address, value, care mask, request/ready) and the lookup channel
// (search key in, per-entry match vector out).
interface ram_based_cam_if #(
    parameter int DATA_BLOCKS = 5,
    parameter int ADDR_WIDTH  = 5
);
    localparam int DATA_WIDTH = 7 * DATA_BLOCKS;
    localparam int WORDS      = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] wcare;
    logic                  start_write;
    logic                  ready;
    logic [DATA_WIDTH-1:0] lookup_data;
    logic [WORDS-1:0]      match_lines;

    // Requester side: programs entries and presents search keys
    modport master (
        output waddr,
        output wdata,
        output wcare,
        output start_write,
        output lookup_data,
        input  ready,
        input  match_lines
    );

    // CAM side
    modport slave (
        input  waddr,
        input  wdata,
        input  wcare,
        input  start_write,
        input  lookup_data,
        output ready,
        output match_lines
    );
endinterface

// File: rtl/ram_based_cam.sv
// RAM-based ternary CAM. Every 7-bit slice of the key owns a 128-row
// bitmap RAM whose row v holds one bit per entry: "this entry accepts
// value v in this slice". A lookup reads one row per slice and ANDs the
// rows. Programming an entry rewrites that entry's column in all RAMs by
// sweeping the 128 rows; reset runs the same sweep to clear everything.
module ram_based_cam #(
    parameter int DATA_BLOCKS = 5,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_based_cam_if.slave  bus
);
    localparam int DATA_WIDTH = 7 * DATA_BLOCKS;
    localparam int WORDS      = 1 << ADDR_WIDTH;
    localparam int ROWS       = 128;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                state;
    logic [6:0]            row_cnt;
    logic                  ready_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wcare_q;

    // Bitmap storage, one 128 x WORDS RAM per key slice
    logic [WORDS-1:0]      ram [DATA_BLOCKS][ROWS];

    // Lookup pipeline registers
    logic [WORDS-1:0]      row_q [DATA_BLOCKS];
    logic [WORDS-1:0]      row_and;
    logic [WORDS-1:0]      match_q;

    // Column bit for the entry being written, one per slice, for the current row
    logic [DATA_BLOCKS-1:0] new_bit;

    // Decide whether the captured pattern accepts the swept row value in each slice
    always_comb begin
        new_bit = '0;
        for (int b = 0; b < DATA_BLOCKS; b++) begin
            new_bit[b] = (((row_cnt ^ wdata_q[7*b +: 7]) & wcare_q[7*b +: 7]) == 7'd0);
        end
    end

    // Sweep controller: clears all rows after reset, then accepts one write at a time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            row_cnt <= 7'd0;
            ready_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wcare_q <= '0;
        end else begin
            case (state)
                ST_INIT, ST_WRITE: begin
                    row_cnt <= row_cnt + 7'd1;
                    if (row_cnt == 7'd127) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.start_write) begin
                        waddr_q <= bus.waddr;
                        wdata_q <= bus.wdata;
                        wcare_q <= bus.wcare;
                        row_cnt <= 7'd0;
                        ready_q <= 1'b0;
                        state   <= ST_WRITE;
                    end
                end
                default: begin
                    state   <= ST_INIT;
                    row_cnt <= 7'd0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port: whole-row clear during init, single-column update during a write
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_BLOCKS; b++) begin
            if (state == ST_INIT) begin
                ram[b][row_cnt] <= '0;
            end else if (state == ST_WRITE) begin
                ram[b][row_cnt][waddr_q] <= new_bit[b];
            end
        end
    end

    // Lookup stage 1: read the row addressed by each key slice (old data on a same-cycle write)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < DATA_BLOCKS; b++) begin
                row_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < DATA_BLOCKS; b++) begin
                row_q[b] <= ram[b][bus.lookup_data[7*b +: 7]];
            end
        end
    end

    // An entry matches only when every slice accepts its part of the key
    always_comb begin
        row_and = '1;
        for (int b = 0; b < DATA_BLOCKS; b++) begin
            row_and = row_and & row_q[b];
        end
    end

    // Lookup stage 2: register the combined match vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= '0;
        end else begin
            match_q <= row_and;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.match_lines = match_q;

endmodule

// File: tb/tb_ram_based_cam.sv
// Testbench for ram_based_cam: directed programming/lookup steps plus
// random keys checked against a behavioural table of ternary patterns.
module tb_ram_based_cam;
    localparam int DATA_BLOCKS = 5;
    localparam int ADDR_WIDTH  = 5;
    localparam int DW          = 7 * DATA_BLOCKS;
    localparam int WORDS       = 1 << ADDR_WIDTH;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ram_based_cam_if #(.DATA_BLOCKS(DATA_BLOCKS), .ADDR_WIDTH(ADDR_WIDTH)) cam_bus ();

    ram_based_cam #(.DATA_BLOCKS(DATA_BLOCKS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cam_bus.slave)
    );

    // Reference table: an entry is a (value, care) pair, or absent
    logic [DW-1:0]    modelData [WORDS];
    logic [DW-1:0]    modelCare [WORDS];
    bit               modelValid[WORDS];

    int               assertCount = 0;
    int               failCount   = 0;
    logic [DW-1:0]    keyQ[$];
    logic [WORDS-1:0] expQ[$];
    int               cycles;

    function automatic logic [WORDS-1:0] modelMatch(input logic [DW-1:0] key);
        logic [WORDS-1:0] m = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (modelValid[i] && (((key ^ modelData[i]) & modelCare[i]) == '0)) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] randKey();
        logic [DW-1:0] k;
        logic [DW-1:0] r;
        int            idx;
        k[31:0]  = $urandom;
        k[34:32] = 3'($urandom_range(0, 7));
        // Half the time steer the key toward a stored entry so hits are common
        if ($urandom_range(0, 1) == 1) begin
            idx = $urandom_range(0, WORDS - 1);
            if (modelValid[idx]) begin
                r = k;
                k = (modelData[idx] & modelCare[idx]) | (r & ~modelCare[idx]);
            end
        end
        return k;
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < WORDS; i++) begin
            modelValid[i] = 1'b0;
            modelData[i]  = '0;
            modelCare[i]  = '0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for ready; returns the number of falling edges waited
    task automatic waitReady(input string tag, output int n);
        n = 0;
        while (cam_bus.ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) checkOutput({tag, "_timeout"}, 64'(cam_bus.ready), 64'd1);
    endtask

    // Pulse start_write for one cycle; returns on the falling edge after the pulse
    task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] addr, input logic [DW-1:0] data,
                                 input logic [DW-1:0] care);
        cam_bus.waddr       = addr;
        cam_bus.wdata       = data;
        cam_bus.wcare       = care;
        cam_bus.start_write = 1'b1;
        @(negedge clk);
        cam_bus.start_write = 1'b0;
    endtask

    task automatic writeEntry(input logic [ADDR_WIDTH-1:0] addr, input logic [DW-1:0] data,
                              input logic [DW-1:0] care);
        int n;
        waitReady("pre_write", n);
        applyStimulus(addr, data, care);
        checkOutput($sformatf("busy_after_accept_a%0d", addr), 64'(cam_bus.ready), 64'd0);
        waitReady("write", n);
        checkOutput($sformatf("write_cycles_a%0d", addr), 64'(n), 64'd128);
        modelData[addr]  = data;
        modelCare[addr]  = care;
        modelValid[addr] = 1'b1;
    endtask

    function automatic void pushKey(input logic [DW-1:0] key);
        keyQ.push_back(key);
        expQ.push_back(modelMatch(key));
    endfunction

    function automatic void pushKeyExp(input logic [DW-1:0] key, input logic [WORDS-1:0] exp);
        keyQ.push_back(key);
        expQ.push_back(exp);
    endfunction

    // Stream queued keys one per clock; each result is checked two edges later
    task automatic runLookups(input string tag);
        int nKeys = keyQ.size();
        for (int n = 0; n < nKeys + 2; n++) begin
            if (n >= 2) checkOutput($sformatf("%s_%0d", tag, n - 2), 64'(cam_bus.match_lines), 64'(expQ[n-2]));
            if (n < nKeys) cam_bus.lookup_data = keyQ[n];
            @(negedge clk);
        end
        keyQ.delete();
        expQ.delete();
    endtask

    initial begin
        cam_bus.start_write = 1'b0;
        cam_bus.waddr       = '0;
        cam_bus.wdata       = '0;
        cam_bus.wcare       = '0;
        cam_bus.lookup_data = '0;
        rst_n               = 1'b0;
        modelClear();

        // Reset state and init sweep length
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 64'(cam_bus.ready), 64'd0);
        checkOutput("reset_match", 64'(cam_bus.match_lines), 64'd0);
        rst_n = 1'b1;
        waitReady("init", cycles);
        checkOutput("init_cycles", 64'(cycles), 64'd128);
        pushKeyExp('0, '0);
        pushKey(randKey());
        runLookups("after_init");

        // Program the four reference entries
        writeEntry(5'd0,  35'h0e3d21200, 35'h7ffffff00);
        writeEntry(5'd5,  35'h013d20000, 35'h7ffff0000);
        writeEntry(5'd7,  35'h001050aff, 35'h7ffffffff);
        writeEntry(5'd31, 35'h013d20100, 35'h7ffffff00);

        // Back-to-back directed lookups
        pushKeyExp(35'h001050aff, 32'h0000_0080);
        pushKeyExp(35'h013d21234, 32'h0000_0020);
        pushKeyExp(35'h013d20134, 32'h8000_0020);
        pushKeyExp(35'h0f3d21212, 32'h0000_0000);
        pushKeyExp(35'h0e3d21212, 32'h0000_0001);
        runLookups("directed");

        // Random keys against the table
        for (int i = 0; i < 30; i++) pushKey(randKey());
        runLookups("rand_a");

        // A write request during a sweep is dropped, not queued
        applyStimulus(5'd3, 35'h012345678, 35'h7ffffffff);
        modelData[3] = 35'h012345678; modelCare[3] = 35'h7ffffffff; modelValid[3] = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(5'd9, 35'h0abcdef12, 35'h7ffffffff);
        waitReady("busy_write", cycles);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("no_queued_write_%0d", i), 64'(cam_bus.ready), 64'd1);
        end
        pushKey(35'h0abcdef12);
        pushKey(35'h012345678);
        runLookups("ignored_write");

        // Entry 7 with an empty care mask matches everything
        writeEntry(5'd7, 35'h001050aff, '0);
        pushKeyExp(35'h013d20134, 32'h8000_00a0);
        pushKeyExp(35'h0e3d21212, 32'h0000_0081);
        for (int i = 0; i < 15; i++) pushKey(randKey());
        runLookups("care_zero");

        // A few random entries, then random keys
        for (int i = 0; i < 3; i++) begin
            logic [DW-1:0] d;
            logic [DW-1:0] c;
            d[31:0] = $urandom; d[34:32] = 3'($urandom_range(0, 7));
            c[31:0] = $urandom | $urandom; c[34:32] = 3'($urandom_range(0, 7));
            writeEntry(5'($urandom_range(0, WORDS - 1)), d, c);
        end
        for (int i = 0; i < 30; i++) pushKey(randKey());
        runLookups("rand_b");

        // Reset in the middle of a write sweep
        applyStimulus(5'd12, 35'h055555555, 35'h7ffffffff);
        cam_bus.lookup_data = 35'h013d20134;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ready", 64'(cam_bus.ready), 64'd0);
        checkOutput("midreset_match", 64'(cam_bus.match_lines), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelClear();
        waitReady("reinit", cycles);
        checkOutput("reinit_cycles", 64'(cycles), 64'd128);
        pushKeyExp(35'h001050aff, '0);
        pushKeyExp(35'h013d20134, '0);
        for (int i = 0; i < 10; i++) pushKey(randKey());
        runLookups("after_reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/ram_based_cam.md
# ram_based_cam

RAM-based ternary CAM for packet-classification / routing lookups. It stores up to `2^ADDR_WIDTH` entries of `DATA_BLOCKS*7` bits, each with a per-bit care mask. It returns a one-hot-per-entry match vector for every lookup key at a rate of one key per clock. Each 7-bit key slice indexes its own 128-row bitmap RAM; the final match is the AND of the per-block rows.

## Interface
- `DATA_BLOCKS`, 5, number of 7-bit key blocks; `DATA_WIDTH = 7*DATA_BLOCKS`
- `ADDR_WIDTH`, 5, entry address width; `WORDS = 2^ADDR_WIDTH`
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `waddr`  in  ADDR_WIDTH  entry to program
- `wdata`  in  DATA_WIDTH  entry value
- `wcare`  in  DATA_WIDTH  care mask; 1 = bit compared, 0 = don't care
- `start_write`  in  1  write request, sampled only while `ready`=1
- `ready`  out  1  1 = idle, write can be accepted; 0 = init/write sweep running
- `lookup_data`  in  DATA_WIDTH  search key, one per clock
- `match_lines`  out  WORDS  bit i = 1 when entry i matches the key

## Operation
- Storage: one RAM per block b (block b = bits `[7b+6:7b]`), 128 rows × WORDS bits.
  - Bit i of row v means: block b of entry i accepts value v.
- Lookup: read row `lookup_data` block b from each RAM; `match_lines` = bitwise AND of the DATA_BLOCKS rows.
- Write of entry `waddr`:
  - `wdata`, `wcare` and `waddr` are captured when `start_write` is accepted.
  - Then a 7-bit counter v sweeps 0..127, one row per clock, in all blocks in parallel.
  - Each row's bit `waddr` becomes `((v ^ wdata_b) & wcare_b) == 0`.
  - Other bits of the row are unchanged (per-bit write enable or read-modify-write).
- Init: reset starts the same sweep, clearing every row to 0. After init no entry matches any key.
- There is no explicit delete operation.
  - Overwriting an entry replaces its previous pattern completely.
  - `wcare` = 0 makes the entry match every key.
- Multiple entries may match a key; every matching bit is set (no priority encoding).
- `start_write` while `ready`=0 is ignored and not queued.
- Lookups during a sweep are legal but return partially updated results; they are only guaranteed correct once `ready`=1.
- Where a lookup reads a row in the same cycle that row is written, the lookup returns the old data.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `ready`=0, `match_lines`=0, sweep counter=0, mode=init.
- After `rst_n` deasserts:
  - Rows 0..127 are cleared on 128 consecutive rising edges.
  - `ready` rises on the edge that clears row 127.
- Write accept: rising edge with `ready`=1 and `start_write`=1 (edge E0).
  - On E0, `ready`=0 and the counter is set to 0.
  - Rows 0..127 are written on E1..E128.
  - `ready`=1 after E128. Write occupancy is 128 cycles plus the accept edge.
- Reset asserted mid-sweep aborts the write and restarts init.
- Lookup latency is 2 rising edges, fully pipelined:
  - Edge 1 registers the RAM row reads for the key.
  - Edge 2 registers the AND into `match_lines`.
  - A key presented before edge k appears on `match_lines` after edge k+1.
  - A new key may be applied every cycle.
- `match_lines` is a registered output and holds its value between updates.

## Test plan
All tests use DATA_BLOCKS=5 and ADDR_WIDTH=5.
- Reset, then wait for `ready`:
  - `ready` rises 128 edges after release.
  - Key 0 gives `match_lines`=0.
- Program four entries, pulsing `start_write` one cycle each and waiting for `ready` between writes:
  - addr 0: data `0e3d21200`, care `fffffff00`
  - addr 5: data `013d20000`, care `fffff0000`
  - addr 7: data `001050aff`, care `fffffffff`
  - addr 31: data `013d20100`, care `fffffff00`
- Back-to-back lookups, one per clock, each checked 2 cycles later:
  - `001050aff` → `1<<7`
  - `013d21234` → `1<<5`
  - `013d20134` → `(1<<5)|(1<<31)`
  - `0f3d21212` → 0
  - `0e3d21212` → 1
- Pulse `start_write` while `ready`=0 → ignored; table unchanged after the current sweep.
- Reprogram addr 7 with data `001050aff`, care 0 → any key matches addr 7; other entries unaffected.
- Assert `rst_n` mid-write → `ready`=0 and `match_lines`=0 immediately; after re-init all lookups return 0.
